wb_crossbar_master_port: RTL and testbench

- Per-master front end of the Wishbone crossbar; one instance per master port, sitting between that master and the crossbar arbiter.
- Decodes the master's address to a target slave and raises that slave's request line towards the arbiter.
- Holds the allocation after grant and routes classic (non-pipelined) Wishbone cycles to the granted slave.
- Releases the allocation when the master ends its cycle, and generates error and timeout responses.

---
 rtl/wb_crossbar_master_port.sv | 178 +++++++++++++++++
 tb/tb_wb_crossbar_master_port.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_crossbar_master_port.sv
// Per-master front end of the Wishbone crossbar: decodes the master address,
// requests the target slave from the arbiter, routes classic cycles once
// granted, and generates decode-error and timeout responses.
module wb_crossbar_master_port #(
  parameter int unsigned               NS         = 2,
  parameter int unsigned               AW         = 32,
  parameter int unsigned               DW         = 32,
  parameter logic [NS-1:0][AW-1:0]     SLAVE_BASE = '0,
  parameter logic [NS-1:0][AW-1:0]     SLAVE_MASK = '0,
  parameter int unsigned               TIMEOUT    = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_m_cyc,
  input  logic                   i_m_stb,
  input  logic                   i_m_we,
  input  logic [AW-1:0]          i_m_adr,
  input  logic [DW-1:0]          i_m_dat,
  input  logic [DW/8-1:0]        i_m_sel,
  output logic                   o_m_ack,
  output logic                   o_m_err,
  output logic [DW-1:0]          o_m_dat,
  output logic [NS-1:0]          o_requested,
  output logic [NS-1:0]          o_allocated,
  output logic                   o_m_allocated,
  input  logic [NS-1:0]          i_granted,
  output logic [NS-1:0]          o_s_cyc,
  output logic [NS-1:0]          o_s_stb,
  output logic                   o_s_we,
  output logic [AW-1:0]          o_s_adr,
  output logic [DW-1:0]          o_s_dat,
  output logic [DW/8-1:0]        o_s_sel,
  input  logic [NS-1:0]          i_s_ack,
  input  logic [NS-1:0]          i_s_err,
  input  logic [NS-1:0][DW-1:0]  i_s_dat
);

  localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  // Reject unusable parameterisations at elaboration
  if (NS < 1) begin : g_chk_ns
    $error("wb_crossbar_master_port: NS must be at least 1");
  end
  if ((DW == 0) || ((DW % 8) != 0)) begin : g_chk_dw
    $error("wb_crossbar_master_port: DW must be a non-zero multiple of 8");
  end
  if (TIMEOUT < 1) begin : g_chk_to
    $error("wb_crossbar_master_port: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_OWN,
    S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] r_sel_q, r_sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_pend_q, err_pend_d;

  logic          hit_any;
  logic [SW-1:0] tgt;
  logic          sel_ok;
  logic          timeout_hit;
  logic          m_err;

  // Address decode; the lowest-indexed matching slave wins
  always_comb begin
    hit_any = 1'b0;
    tgt     = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      if (!hit_any && ((i_m_adr & SLAVE_MASK[s]) == SLAVE_BASE[s])) begin
        hit_any = 1'b1;
        tgt     = SW'(s);
      end
    end
  end

  // State register, latched target, timeout counter and deferred error flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      r_sel_q    <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_sel_q    <= r_sel_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
    end
  end

  // Next-state and routing; all outputs are decoded from state and live inputs
  always_comb begin
    state_d       = state_q;
    r_sel_d       = r_sel_q;
    cnt_d         = '0;
    err_pend_d    = 1'b0;
    sel_ok        = hit_any && (tgt == r_sel_q);
    timeout_hit   = (state_q == S_OWN) && (cnt_q == CW'(TIMEOUT));
    m_err         = 1'b0;
    o_m_ack       = 1'b0;
    o_m_err       = 1'b0;
    o_m_dat       = '0;
    o_requested   = '0;
    o_allocated   = '0;
    o_m_allocated = 1'b0;
    o_s_cyc       = '0;
    o_s_stb       = '0;
    o_s_we        = 1'b0;
    o_s_adr       = '0;
    o_s_dat       = '0;
    o_s_sel       = '0;

    case (state_q)
      S_IDLE: begin
        if (i_m_cyc && i_m_stb) begin
          if (hit_any) begin
            r_sel_d = tgt;
            state_d = S_REQUEST;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_REQUEST: begin
        o_requested[r_sel_q] = 1'b1;
        if (!i_m_cyc) begin
          state_d = S_IDLE;
        end else if (i_granted[r_sel_q]) begin
          state_d = S_OWN;
        end
      end

      S_OWN: begin
        // Request stays up: the arbiter keeps the grant only while requested && allocated
        o_requested[r_sel_q] = 1'b1;
        o_allocated[r_sel_q] = 1'b1;
        o_m_allocated        = 1'b1;
        o_s_cyc[r_sel_q]     = i_m_cyc;
        o_s_stb[r_sel_q]     = i_m_stb && sel_ok && !timeout_hit;
        o_s_we               = i_m_we;
        o_s_adr              = i_m_adr;
        o_s_dat              = i_m_dat;
        o_s_sel              = i_m_sel;
        m_err                = i_s_err[r_sel_q] || err_pend_q || timeout_hit;
        o_m_err              = m_err;
        o_m_ack              = i_s_ack[r_sel_q] && !m_err;
        o_m_dat              = i_s_dat[r_sel_q];
        // A strobe to a slave we do not own is answered with an error next cycle
        err_pend_d           = i_m_cyc && i_m_stb && !sel_ok && !err_pend_q;
        if (i_m_stb && !i_s_ack[r_sel_q] && !m_err) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (!i_m_cyc) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          err_pend_d = 1'b0;
        end
      end

      S_ERR: begin
        o_m_err = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_crossbar_master_port.sv
// Randomised scoreboard bench for wb_crossbar_master_port with a behavioural
// slave/arbiter environment and a transaction-level reference model.
module tb_wb_crossbar_master_port;

  localparam int NS = 2;
  localparam int TO = 4;
  localparam logic [NS-1:0][31:0] BASE = {32'h1000_0000, 32'h0000_0000};
  localparam logic [NS-1:0][31:0] MASK = {32'hF000_0000, 32'hF000_0000};

  logic clk = 1'b0;
  logic rst;
  logic m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        o_m_ack, o_m_err;
  logic [31:0] o_m_dat;
  logic [NS-1:0] o_requested, o_allocated, granted, o_s_cyc, o_s_stb;
  logic          o_m_allocated, o_s_we;
  logic [31:0]   o_s_adr, o_s_dat;
  logic [3:0]    o_s_sel;
  logic [NS-1:0] s_ack, s_err;
  logic [NS-1:0][31:0] s_dat;

  always #5 clk = ~clk;

  wb_crossbar_master_port #(
    .NS(NS), .AW(32), .DW(32), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel), .o_m_ack(o_m_ack),
    .o_m_err(o_m_err), .o_m_dat(o_m_dat), .o_requested(o_requested),
    .o_allocated(o_allocated), .o_m_allocated(o_m_allocated), .i_granted(granted),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_adr(o_s_adr),
    .o_s_dat(o_s_dat), .o_s_sel(o_s_sel), .i_s_ack(s_ack), .i_s_err(s_err),
    .i_s_dat(s_dat)
  );

  int checks = 0;
  int fails  = 0;
  int cyc_n  = 0;

  typedef struct {
    logic [1:0]  kind;   // {ack, err}
    logic [31:0] dat;
    logic        chk_dat;
    int          start;
    int          lat;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   next_id = 0;

  logic [127:0] outs_all;
  always_comb outs_all = 128'({o_m_ack, o_m_err, o_m_dat, o_requested, o_allocated,
                               o_m_allocated, o_s_cyc, o_s_stb, o_s_we, o_s_adr,
                               o_s_dat, o_s_sel});

  // Slave and arbiter environment controls
  int   smode  = 0;      // 0 ack, 1 err, 2 silent, 3 ack+err
  int   gdelay = 0;
  logic gen    = 1'b1;
  int   rcnt;
  logic [NS-1:0] s_rsp_q;
  logic [31:0]   smem  [NS][4];
  logic [31:0]   mmem  [NS][4];

  function automatic logic [31:0] init_word(input int s, input int w);
    if (s == 1 && w == 1) return 32'hDEADBEEF;
    return 32'h1234_5678 + 32'(s * 32'h0101_0000) + 32'(w * 32'h11);
  endfunction

  function automatic int decode(input logic [31:0] a);
    for (int s = 0; s < NS; s++)
      if ((a & MASK[s]) == BASE[s]) return s;
    return -1;
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Behavioural slaves: registered single-cycle response, byte-masked writes
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rsp_q <= '0;
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < 4; w++) smem[s][w] <= init_word(s, w);
    end else begin
      for (int s = 0; s < NS; s++) begin
        s_rsp_q[s] <= o_s_stb[s] && !s_rsp_q[s] && (smode != 2);
        if (o_s_stb[s] && s_rsp_q[s] && o_s_we && smode == 0)
          for (int b = 0; b < 4; b++)
            if (o_s_sel[b]) smem[s][o_s_adr[3:2]][8*b +: 8] <= o_s_dat[8*b +: 8];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      s_ack[s] = s_rsp_q[s] && (smode == 0 || smode == 3);
      s_err[s] = s_rsp_q[s] && (smode == 1 || smode == 3);
      s_dat[s] = smem[s][o_s_adr[3:2]];
    end
  end

  // Arbiter: grants a request once it has been pending gdelay cycles
  always @(posedge clk or posedge rst) begin
    if (rst) rcnt <= 0;
    else if (o_requested == '0) rcnt <= 0;
    else rcnt <= rcnt + 1;
  end
  always_comb granted = (gen && rcnt >= gdelay) ? o_requested : '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [31:0] dat, input logic chk_dat,
                      input int start, input int lat);
    exp_t e;
    e.kind = kind; e.dat = dat; e.chk_dat = chk_dat;
    e.start = start; e.lat = lat; e.id = next_id;
    next_id++;
    sb.push_back(e);
  endtask

  // Monitor: every ack/err the master sees must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (o_m_ack || o_m_err)) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 128'({o_m_ack, o_m_err}), 128'(0));
      end else begin
        e = sb.pop_front();
        check($sformatf("rsp%0d_kind", e.id), 128'({o_m_ack, o_m_err}), 128'(e.kind));
        check($sformatf("rsp%0d_lat", e.id), 128'(cyc_n - e.start), 128'(e.lat));
        if (e.chk_dat) check($sformatf("rsp%0d_dat", e.id), 128'(o_m_dat), 128'(e.dat));
      end
    end
  end

  task automatic wait_rsp(input string nm);
    int n = 0;
    @(negedge clk);
    while (!(o_m_ack || o_m_err) && n < 64) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_wait"}, 128'(n >= 64), 128'(0));
  endtask

  // One complete master cycle; the expected response comes from the address
  // map, the slave behaviour and the arbiter delay
  task automatic access(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                        input logic [3:0] sel, input int mode, input int gd);
    int tgt, st, w;
    logic [NS-1:0] oh;
    tgt = decode(adr);
    w   = int'(adr[3:2]);
    oh  = (tgt >= 0) ? (NS'(1) << tgt) : '0;
    smode = mode; gdelay = gd; gen = 1'b1;
    @(posedge clk); #1;
    st = cyc_n;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat = wd; m_sel = sel;
    if (tgt < 0) push(2'b01, '0, 1'b0, st, 1);
    else if (mode == 0) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) mmem[tgt][w][8*b +: 8] = wd[8*b +: 8];
        push(2'b10, '0, 1'b0, st, 3 + gd);
      end else push(2'b10, mmem[tgt][w], 1'b1, st, 3 + gd);
    end
    else if (mode == 2) push(2'b01, '0, 1'b0, st, 2 + gd + TO);
    else push(2'b01, '0, 1'b0, st, 3 + gd);
    wait_rsp("access");
    if (tgt < 0) check("unmapped_req", 128'(o_requested), 128'(0));
    else begin
      check("own_alloc", 128'({o_allocated, o_m_allocated}), 128'({oh, 1'b1}));
      check("own_stb", 128'(o_s_stb), 128'((mode == 2) ? '0 : oh));
    end
    @(posedge clk); #1;
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    if (tgt >= 0) check("hold_alloc", 128'(o_allocated), 128'(oh));
    @(negedge clk);
    check("release", 128'({o_requested, o_allocated, o_s_cyc}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int st, r, md;
    logic [31:0] a;
    rst = 1'b1;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < 4; w++) mmem[s][w] = init_word(s, w);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", outs_all, 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_outs", outs_all, 128'(0));

    // Read from slave 1, grant one cycle after request
    access(32'h1000_0004, 1'b0, '0, 4'hF, 0, 1);
    // Unmapped address
    access(32'h2000_0000, 1'b0, '0, 4'hF, 0, 0);

    // No grant: request held, nothing reaches a slave
    gen = 1'b0;
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0000_0004;
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("nogrant_req", 128'({o_requested, o_s_stb, o_s_cyc}), 128'({2'b01, 2'b00, 2'b00}));
    end
    @(posedge clk); #1; m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    check("nogrant_req_hold", 128'(o_requested), 128'(2'b01));
    @(negedge clk);
    check("nogrant_req_drop", 128'({o_requested, o_s_stb}), 128'(0));
    gen = 1'b1;

    // Owning slave 0, strobe to slave 1 under the same cycle
    smode = 0; gdelay = 0;
    @(posedge clk); #1;
    st = cyc_n; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0000_0008;
    push(2'b10, mmem[0][2], 1'b1, st, 3);
    wait_rsp("t4a");
    @(posedge clk); #1; m_stb = 1'b0;
    @(posedge clk); #1;
    st = cyc_n; m_stb = 1'b1; m_adr = 32'h1000_0000;
    push(2'b01, '0, 1'b0, st, 1);
    @(negedge clk);
    check("foreign_stb_blocked", 128'(o_s_stb), 128'(0));
    wait_rsp("t4b");
    check("foreign_keep_own", 128'({o_allocated, o_s_stb}), 128'({2'b01, 2'b00}));
    @(posedge clk); #1; m_stb = 1'b0;
    @(posedge clk); #1;
    st = cyc_n; m_stb = 1'b1; m_adr = 32'h0000_000C;
    push(2'b10, mmem[0][3], 1'b1, st, 1);
    wait_rsp("t4c");
    @(posedge clk); #1; m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t4_release", 128'({o_requested, o_allocated}), 128'(0));

    // Silent slave: timeout error, then the count restarts while stb is held
    smode = 2; gdelay = 0;
    @(posedge clk); #1;
    st = cyc_n; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0000_0004;
    push(2'b01, '0, 1'b0, st, 2 + TO);
    push(2'b01, '0, 1'b0, st, 2 + TO + TO + 1);
    wait_rsp("t5a");
    check("to_stb_gated", 128'({o_s_stb, o_allocated}), 128'({2'b00, 2'b01}));
    @(negedge clk);
    check("to_stb_resumed", 128'(o_s_stb), 128'(2'b01));
    wait_rsp("t5b");
    check("to2_stb_gated", 128'(o_s_stb), 128'(0));
    @(posedge clk); #1; m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk); @(negedge clk);

    // Simultaneous slave ack and err
    access(32'h1000_0000, 1'b0, '0, 4'hF, 3, 2);

    // Held unmapped strobe: one error every two cycles, never a request
    @(posedge clk); #1;
    st = cyc_n; m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h3000_0000;
    push(2'b01, '0, 1'b0, st, 1);
    push(2'b01, '0, 1'b0, st, 3);
    push(2'b01, '0, 1'b0, st, 5);
    repeat (6) begin
      @(negedge clk);
      check("err_repeat_noreq", 128'(o_requested), 128'(0));
    end
    @(posedge clk); #1; m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);

    // Reset while owning slave 1
    smode = 2; gdelay = 0;
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h1000_0008;
    repeat (3) @(negedge clk);
    check("rst_pre_own", 128'(o_allocated), 128'(2'b10));
    #1 rst = 1'b1;
    #1;
    check("rst_async_clear", 128'({o_requested, o_allocated, o_s_cyc, o_s_stb, o_m_allocated}), 128'(0));
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < 4; w++) mmem[s][w] = init_word(s, w);
    @(negedge clk);
    check("rst_idle_outs", outs_all, 128'(0));

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 4);
      a = $urandom;
      a[1:0] = 2'b00;
      if (r < 2) a[31:28] = 4'h0;
      else if (r < 4) a[31:28] = 4'h1;
      else a[31:28] = 4'($urandom_range(2, 15));
      md = $urandom_range(0, 9);
      if (md < 6 || md == 9) md = 0;
      else md = md - 5;
      access(a, 1'($urandom), $urandom, 4'($urandom), md, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
